// File: rtl/nanorv32_pipe_ctrl_pkg.sv
// Shared nanorv32 pipeline-control definitions: pstate encodings, the
// per-cycle control output bundle and small width helpers.
package nanorv32_pipe_ctrl_pkg;

    localparam int PSTATE_W = 3;

    localparam logic [PSTATE_W-1:0] PSTATE_RESET  = 3'd0;
    localparam logic [PSTATE_W-1:0] PSTATE_CONT   = 3'd1;
    localparam logic [PSTATE_W-1:0] PSTATE_BRANCH = 3'd2;
    localparam logic [PSTATE_W-1:0] PSTATE_STALL  = 3'd3;
    localparam logic [PSTATE_W-1:0] PSTATE_WAITLD = 3'd4;
    localparam logic [PSTATE_W-1:0] PSTATE_IRQ    = 3'd5;

    typedef struct packed {
        logic stall;
        logic stall_reset;
        logic new_pc;
        logic valid_inst;
        logic data_access;
        logic bypass;
        logic timeout_err;
    } pipe_ctrl_out_t;

    localparam pipe_ctrl_out_t CTRL_DEFAULT = '{
        stall:       1'b0,
        stall_reset: 1'b0,
        new_pc:      1'b0,
        valid_inst:  1'b1,
        data_access: 1'b0,
        bypass:      1'b0,
        timeout_err: 1'b0
    };

    // Index width for n request lines, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nanorv32_pipe_ctrl_if.sv
// Pipeline-control bundle between the core datapath (master) and the
// pipeline controller (slave).
interface nanorv32_pipe_ctrl_if #(
    parameter int NB_IRQ  = 4,
    parameter int UROM_AW = 5
);
    import nanorv32_pipe_ctrl_pkg::*;

    localparam int IRQ_IDW = id_width(NB_IRQ);

    // hreadyd and codeif_cpu_ready_r act as ready for the request the
    // controller is currently holding: it completes in the cycle ready is
    // sampled high at the clock edge, and is re-held every cycle until then.
    // Controller outputs carry no valid of their own and are meaningful
    // every cycle.
    logic                  branch_taken;
    logic                  datamem_read;
    logic                  datamem_write;
    logic                  hreadyd;
    logic                  codeif_cpu_ready_r;
    logic [NB_IRQ-1:0]     irq;
    logic                  irq_enable;

    logic                  force_stall_pstate;
    logic                  force_stall_reset;
    logic                  output_new_pc;
    logic                  valid_inst;
    logic                  data_access_cycle;
    logic [PSTATE_W-1:0]   pstate_r;
    logic [NB_IRQ-1:0]     irq_ack;
    logic [IRQ_IDW-1:0]    irq_id;
    logic                  irq_bypass_inst_reg;
    logic [UROM_AW-1:0]    urom_addr;
    logic                  bus_timeout_err;

    modport master (
        output branch_taken, datamem_read, datamem_write, hreadyd,
               codeif_cpu_ready_r, irq, irq_enable,
        input  force_stall_pstate, force_stall_reset, output_new_pc,
               valid_inst, data_access_cycle, pstate_r, irq_ack, irq_id,
               irq_bypass_inst_reg, urom_addr, bus_timeout_err
    );

    modport slave (
        input  branch_taken, datamem_read, datamem_write, hreadyd,
               codeif_cpu_ready_r, irq, irq_enable,
        output force_stall_pstate, force_stall_reset, output_new_pc,
               valid_inst, data_access_cycle, pstate_r, irq_ack, irq_id,
               irq_bypass_inst_reg, urom_addr, bus_timeout_err
    );

endinterface

// File: rtl/nanorv32_irq_arb.sv
// Fixed-priority interrupt arbiter: lowest requesting index wins; the
// winner is captured into irq_id when the controller takes the interrupt.
module nanorv32_irq_arb
    import nanorv32_pipe_ctrl_pkg::*;
#(
    parameter int  NB_IRQ = 4,
    localparam int IDW    = id_width(NB_IRQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NB_IRQ-1:0] irq,
    input  logic              capture,
    output logic              req_any,
    output logic [IDW-1:0]    sel_id,
    output logic [NB_IRQ-1:0] sel_onehot,
    output logic [IDW-1:0]    irq_id
);

    assign req_any = |irq;

    // Two's-complement trick isolates the lowest set request bit.
    assign sel_onehot = irq & (~irq + 1'b1);

    always_comb begin
        sel_id = '0;
        for (int i = NB_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) begin
                sel_id = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_id <= '0;
        end else if (capture) begin
            irq_id <= sel_id;
        end
    end

endmodule

// File: rtl/nanorv32_pipe_ctrl.sv
// nanorv32 pipeline controller: sequences branches, load/store waits with
// timeout, and micro-ROM interrupt-entry sequences.
module nanorv32_pipe_ctrl
    import nanorv32_pipe_ctrl_pkg::*;
#(
    parameter int NB_IRQ      = 4,
    parameter int UROM_AW     = 5,
    parameter int IRQ_SEQ_LEN = 4,
    parameter int BUS_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nanorv32_pipe_ctrl_if.slave  bus
);

    localparam int IDW        = id_width(NB_IRQ);
    localparam int WAIT_W     = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam int SEQ_W      = (IRQ_SEQ_LEN > 1) ? $clog2(IRQ_SEQ_LEN) : 1;
    localparam bit TIMEOUT_EN = (BUS_TIMEOUT > 0);

    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((BUS_TIMEOUT > 0) ? (BUS_TIMEOUT - 1) : 0);
    localparam logic [SEQ_W-1:0]  SEQ_LAST  = SEQ_W'(IRQ_SEQ_LEN - 1);

    logic [PSTATE_W-1:0] pstate_r;
    logic [PSTATE_W-1:0] pstate_nxt;
    logic [PSTATE_W-1:0] cur_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [SEQ_W-1:0]    seq_cnt;
    logic [UROM_AW-1:0]  urom_addr_r;
    logic [UROM_AW-1:0]  urom_base;
    logic [NB_IRQ-1:0]   irq_ack_r;
    pipe_ctrl_out_t      ctrl;
    logic                take_irq;
    logic                timeout_hit;

    logic                arb_req_any;
    logic [IDW-1:0]      arb_sel_id;
    logic [NB_IRQ-1:0]   arb_sel_onehot;
    logic [IDW-1:0]      arb_irq_id;

    nanorv32_irq_arb #(
        .NB_IRQ (NB_IRQ)
    ) u_irq_arb (
        .clk        (clk),
        .rst        (rst),
        .irq        (bus.irq),
        .capture    (take_irq),
        .req_any    (arb_req_any),
        .sel_id     (arb_sel_id),
        .sel_onehot (arb_sel_onehot),
        .irq_id     (arb_irq_id)
    );

    // While rst is high the outputs decode as RESET, so a pending timeout or
    // branch in the abandoned state never leaks out during the reset cycle.
    assign cur_state   = rst ? PSTATE_RESET : pstate_r;
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
    assign urom_base   = UROM_AW'(arb_sel_id) * UROM_AW'(IRQ_SEQ_LEN);

    always_comb begin
        ctrl       = CTRL_DEFAULT;
        pstate_nxt = PSTATE_CONT;
        take_irq   = 1'b0;
        case (cur_state)
            PSTATE_RESET: begin
                ctrl.stall       = 1'b1;
                ctrl.stall_reset = 1'b1;
                pstate_nxt       = PSTATE_CONT;
            end
            PSTATE_CONT: begin
                if (bus.branch_taken) begin
                    ctrl.stall   = 1'b1;
                    ctrl.new_pc  = 1'b1;
                    pstate_nxt   = PSTATE_BRANCH;
                end else if (bus.datamem_read || bus.datamem_write) begin
                    ctrl.stall       = 1'b1;
                    ctrl.data_access = 1'b1;
                    pstate_nxt       = PSTATE_WAITLD;
                end else if (bus.irq_enable && arb_req_any) begin
                    take_irq   = 1'b1;
                    pstate_nxt = PSTATE_IRQ;
                end else begin
                    pstate_nxt = PSTATE_CONT;
                end
            end
            PSTATE_BRANCH: begin
                ctrl.new_pc = 1'b1;
                if (bus.codeif_cpu_ready_r) begin
                    pstate_nxt = PSTATE_CONT;
                end else begin
                    ctrl.stall = 1'b1;
                    pstate_nxt = PSTATE_BRANCH;
                end
            end
            PSTATE_STALL: begin
                ctrl.valid_inst = 1'b0;
                if (bus.codeif_cpu_ready_r) begin
                    pstate_nxt = PSTATE_CONT;
                end else begin
                    ctrl.stall = 1'b1;
                    pstate_nxt = PSTATE_STALL;
                end
            end
            PSTATE_WAITLD: begin
                if (bus.hreadyd) begin
                    pstate_nxt = PSTATE_CONT;
                end else if (timeout_hit) begin
                    ctrl.timeout_err = 1'b1;
                    pstate_nxt       = PSTATE_CONT;
                end else begin
                    ctrl.stall = 1'b1;
                    pstate_nxt = PSTATE_WAITLD;
                end
            end
            PSTATE_IRQ: begin
                ctrl.bypass = 1'b1;
                if (bus.branch_taken) begin
                    ctrl.new_pc = 1'b1;
                    ctrl.stall  = 1'b1;
                    pstate_nxt  = PSTATE_BRANCH;
                end else if (seq_cnt == SEQ_LAST) begin
                    pstate_nxt = PSTATE_CONT;
                end else begin
                    pstate_nxt = PSTATE_IRQ;
                end
            end
            default: begin
                pstate_nxt = PSTATE_CONT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_r    <= PSTATE_RESET;
            wait_cnt    <= '0;
            seq_cnt     <= '0;
            urom_addr_r <= '0;
            irq_ack_r   <= '0;
        end else begin
            pstate_r  <= pstate_nxt;
            irq_ack_r <= take_irq ? arb_sel_onehot : '0;

            // Counts only while staying in WAITLD; saturates if never timed out.
            if (pstate_r == PSTATE_WAITLD && pstate_nxt == PSTATE_WAITLD) begin
                if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end

            if (take_irq) begin
                seq_cnt     <= '0;
                urom_addr_r <= urom_base;
            end else if (pstate_r == PSTATE_IRQ) begin
                seq_cnt     <= seq_cnt + 1'b1;
                urom_addr_r <= urom_addr_r + 1'b1;
            end
        end
    end

    assign bus.force_stall_pstate  = ctrl.stall;
    assign bus.force_stall_reset   = ctrl.stall_reset;
    assign bus.output_new_pc       = ctrl.new_pc;
    assign bus.valid_inst          = ctrl.valid_inst;
    assign bus.data_access_cycle   = ctrl.data_access;
    assign bus.irq_bypass_inst_reg = ctrl.bypass;
    assign bus.bus_timeout_err     = ctrl.timeout_err;
    assign bus.pstate_r            = pstate_r;
    assign bus.irq_ack             = irq_ack_r;
    assign bus.irq_id              = arb_irq_id;
    assign bus.urom_addr           = urom_addr_r;

endmodule

// File: tb/tb_nanorv32_pipe_ctrl.sv
// Bench for nanorv32_pipe_ctrl: directed scenarios then random traffic, all
// checked each cycle against a behavioural model of the controller rules.
module tb_nanorv32_pipe_ctrl;
    import nanorv32_pipe_ctrl_pkg::*;

    localparam int NB_IRQ      = 4;
    localparam int UROM_AW     = 5;
    localparam int IRQ_SEQ_LEN = 4;
    localparam int BUS_TIMEOUT = 16;
    localparam int IDW         = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nanorv32_pipe_ctrl_if #(.NB_IRQ(NB_IRQ), .UROM_AW(UROM_AW)) bus ();

    nanorv32_pipe_ctrl #(
        .NB_IRQ      (NB_IRQ),
        .UROM_AW     (UROM_AW),
        .IRQ_SEQ_LEN (IRQ_SEQ_LEN),
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int stall_cnt, err_cnt, ack_cnt;

    // reference model state
    logic [PSTATE_W-1:0] m_st, n_st;
    logic [UROM_AW-1:0]  m_urom, n_urom;
    logic [IDW-1:0]      m_id, n_id;
    logic [NB_IRQ-1:0]   m_ack, n_ack;
    int                  m_waited, n_waited;
    logic [UROM_AW-1:0]  exp_q[$];
    logic e_stall, e_sreset, e_newpc, e_valid, e_dac, e_byp, e_terr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int lowest(input logic [NB_IRQ-1:0] r);
        for (int i = 0; i < NB_IRQ; i++) if (r[i]) return i;
        return 0;
    endfunction

    task automatic model_eval();
        int id;
        e_stall = 0; e_sreset = 0; e_newpc = 0; e_valid = 1;
        e_dac = 0; e_byp = 0; e_terr = 0;
        n_st = m_st; n_urom = m_urom; n_id = m_id; n_ack = '0; n_waited = m_waited;
        if (rst) begin
            e_stall = 1; e_sreset = 1;
            n_st = PSTATE_RESET; n_urom = '0; n_id = '0; n_waited = 0;
            exp_q.delete();
        end else if (m_st == PSTATE_RESET) begin
            e_stall = 1; e_sreset = 1; n_st = PSTATE_CONT;
        end else if (m_st == PSTATE_CONT) begin
            if (bus.branch_taken) begin
                e_stall = 1; e_newpc = 1; n_st = PSTATE_BRANCH;
            end else if (bus.datamem_read || bus.datamem_write) begin
                e_stall = 1; e_dac = 1; n_st = PSTATE_WAITLD; n_waited = 0;
            end else if (bus.irq_enable && bus.irq != 0) begin
                id     = lowest(bus.irq);
                n_id   = IDW'(id);
                n_ack  = NB_IRQ'(1) << id;
                n_urom = UROM_AW'((id * IRQ_SEQ_LEN) % (1 << UROM_AW));
                for (int k = 0; k < IRQ_SEQ_LEN; k++)
                    exp_q.push_back(UROM_AW'((id * IRQ_SEQ_LEN + k) % (1 << UROM_AW)));
                n_st = PSTATE_IRQ;
            end
        end else if (m_st == PSTATE_BRANCH) begin
            e_newpc = 1;
            if (bus.codeif_cpu_ready_r) n_st = PSTATE_CONT;
            else e_stall = 1;
        end else if (m_st == PSTATE_WAITLD) begin
            if (bus.hreadyd) begin
                n_st = PSTATE_CONT; n_waited = 0;
            end else if (BUS_TIMEOUT > 0 && m_waited == BUS_TIMEOUT - 1) begin
                e_terr = 1; n_st = PSTATE_CONT; n_waited = 0;
            end else begin
                e_stall = 1; n_waited = m_waited + 1;
            end
        end else if (m_st == PSTATE_IRQ) begin
            e_byp = 1;
            if (exp_q.size() > 0) chk("urom_seq", 32'(bus.urom_addr), 32'(exp_q.pop_front()));
            n_urom = m_urom + 1'b1;
            if (bus.branch_taken) begin
                e_newpc = 1; e_stall = 1; n_st = PSTATE_BRANCH; exp_q.delete();
            end else if (exp_q.size() == 0) begin
                n_st = PSTATE_CONT;
            end
        end else begin
            n_st = PSTATE_CONT;
        end
    endtask

    // one checked clock: inputs already driven at the falling edge
    task automatic cyc();
        #1;
        model_eval();
        chk("pstate_r", 32'(bus.pstate_r), 32'(m_st));
        chk("force_stall_pstate", 32'(bus.force_stall_pstate), 32'(e_stall));
        chk("force_stall_reset", 32'(bus.force_stall_reset), 32'(e_sreset));
        chk("output_new_pc", 32'(bus.output_new_pc), 32'(e_newpc));
        chk("valid_inst", 32'(bus.valid_inst), 32'(e_valid));
        chk("data_access_cycle", 32'(bus.data_access_cycle), 32'(e_dac));
        chk("irq_bypass_inst_reg", 32'(bus.irq_bypass_inst_reg), 32'(e_byp));
        chk("bus_timeout_err", 32'(bus.bus_timeout_err), 32'(e_terr));
        chk("irq_ack", 32'(bus.irq_ack), 32'(m_ack));
        chk("irq_id", 32'(bus.irq_id), 32'(m_id));
        chk("urom_addr", 32'(bus.urom_addr), 32'(m_urom));
        stall_cnt += int'(bus.force_stall_pstate);
        err_cnt   += int'(bus.bus_timeout_err);
        if (bus.irq_ack != 0) ack_cnt++;
        @(posedge clk);
        m_st = n_st; m_urom = n_urom; m_id = n_id; m_ack = n_ack; m_waited = n_waited;
        @(negedge clk);
    endtask

    task automatic clr_counts();
        stall_cnt = 0; err_cnt = 0; ack_cnt = 0;
    endtask

    initial begin
        int mode;
        rst = 1'b1;
        bus.branch_taken = 0; bus.datamem_read = 0; bus.datamem_write = 0;
        bus.hreadyd = 1; bus.codeif_cpu_ready_r = 1; bus.irq = '0; bus.irq_enable = 0;
        @(posedge clk);
        @(negedge clk);
        m_st = PSTATE_RESET; m_urom = '0; m_id = '0; m_ack = '0; m_waited = 0;
        clr_counts();

        // reset held, then release: RESET for one cycle, then CONT
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();

        // load with hreadyd low for three wait cycles
        clr_counts();
        bus.datamem_read = 1; bus.hreadyd = 0; cyc();
        bus.datamem_read = 0; repeat (3) cyc();
        bus.hreadyd = 1; cyc(); cyc();
        chk("load_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("load_no_timeout", 32'(err_cnt), 32'd0);

        // store with hreadyd stuck low: timeout
        clr_counts();
        bus.datamem_write = 1; bus.hreadyd = 0; cyc();
        bus.datamem_write = 0; repeat (17) cyc();
        bus.hreadyd = 1; cyc();
        chk("timeout_pulses", 32'(err_cnt), 32'd1);
        chk("timeout_stall_cycles", 32'(stall_cnt), 32'(BUS_TIMEOUT));

        // interrupt from idle CONT, two requests: lowest wins
        clr_counts();
        bus.irq_enable = 1; bus.irq = 4'b0110; cyc();
        bus.irq = '0; repeat (IRQ_SEQ_LEN) cyc(); cyc();
        chk("irq_ack_pulses", 32'(ack_cnt), 32'd1);

        // branch and interrupt together: branch first, fetch not ready once
        clr_counts();
        bus.branch_taken = 1; bus.irq = 4'b0001; cyc();
        bus.branch_taken = 0; bus.codeif_cpu_ready_r = 0; cyc();
        chk("no_ack_during_branch", 32'(ack_cnt), 32'd0);
        bus.codeif_cpu_ready_r = 1; cyc(); cyc();
        bus.irq = '0; repeat (IRQ_SEQ_LEN) cyc();
        chk("deferred_irq_taken", 32'(ack_cnt), 32'd1);

        // requests during IRQ stay pending
        bus.irq = 4'b1000; cyc();
        bus.irq = 4'b0001; repeat (IRQ_SEQ_LEN) cyc();
        cyc(); bus.irq = '0; repeat (IRQ_SEQ_LEN) cyc();

        // branch aborts an interrupt sequence
        bus.irq = 4'b0100; cyc();
        bus.irq = '0; cyc();
        bus.branch_taken = 1; cyc();
        bus.branch_taken = 0; cyc(); cyc();

        // interrupts masked
        bus.irq_enable = 0; bus.irq = 4'b1111; cyc(); cyc();
        bus.irq = '0; bus.irq_enable = 1;

        // reset in the second IRQ cycle
        clr_counts();
        bus.irq = 4'b0010; cyc();
        bus.irq = '0; cyc();
        rst = 1'b1; cyc(); cyc();
        rst = 1'b0; cyc(); cyc(); cyc();
        chk("reset_irq_ack_pulses", 32'(ack_cnt), 32'd1);

        // random traffic
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) mode = $urandom_range(0, 1);
            rst                    = ($urandom_range(0, 199) == 0);
            bus.branch_taken       = ($urandom_range(0, 9) == 0);
            bus.datamem_read       = ($urandom_range(0, 11) == 0);
            bus.datamem_write      = ($urandom_range(0, 11) == 0);
            bus.hreadyd            = mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            bus.codeif_cpu_ready_r = ($urandom_range(0, 3) != 0);
            bus.irq                = ($urandom_range(0, 2) == 0) ? NB_IRQ'($urandom_range(0, 15)) : '0;
            bus.irq_enable         = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nanorv32_pipe_ctrl.md
NANORV32_PIPE_CTRL -- requirements
Module: nanorv32_pipe_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NB_IRQ, 4, interrupt request lines (1..16).
- UROM_AW, 5, micro-ROM address width.
- IRQ_SEQ_LEN, 4, micro-ROM words per interrupt-entry sequence (2..2**UROM_AW).
- BUS_TIMEOUT, 16, max data-wait cycles; 0 disables timeout.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- branch_taken  in  1  execute stage resolves taken branch.
- datamem_read  in  1  load in execute.
- datamem_write  in  1  store in execute.
- hreadyd  in  1  data bus ready.
- codeif_cpu_ready_r  in  1  fetch word available.
- irq  in  NB_IRQ  level interrupt requests.
- irq_enable  in  1  global interrupt enable.
- force_stall_pstate  out  1  stall pipeline.
- force_stall_reset  out  1  reset-phase stall.
- output_new_pc  out  1  drive branch target to fetch.
- valid_inst  out  1  instruction register valid.
- data_access_cycle  out  1  address phase of data access.
- pstate_r  out  3  current state.
- irq_ack  out  NB_IRQ  one-hot acknowledge pulse.
- irq_id  out  clog2(NB_IRQ) (min 1)  captured interrupt index.
- irq_bypass_inst_reg  out  1  execute micro-ROM word instead of fetched instruction.
- urom_addr  out  UROM_AW  micro-ROM address.
- bus_timeout_err  out  1  one-cycle pulse on data-wait timeout.

Function
REQ-004 States SHALL be RESET, CONT, BRANCH, STALL, WAITLD, IRQ; default outputs per cycle: valid_inst=1, all others 0.
REQ-005 RESET SHALL assert force_stall_pstate and force_stall_reset, next CONT.
REQ-006 CONT priority SHALL be: branch_taken (stall, output_new_pc, next BRANCH) > datamem_read|write (stall, data_access_cycle, next WAITLD) > interrupt take > stay CONT.
REQ-007 Interrupt take SHALL occur only in CONT with irq_enable=1 and irq!=0; lowest index wins; irq_id is captured; next IRQ.
REQ-008 BRANCH SHALL assert output_new_pc; next CONT with no stall if codeif_cpu_ready_r, else stay with stall.
REQ-009 STALL SHALL deassert valid_inst; exit to CONT on codeif_cpu_ready_r, else stay with stall.
REQ-010 WAITLD SHALL exit to CONT with no stall on hreadyd=1, else stay with stall and increment the wait counter.
REQ-011 With BUS_TIMEOUT>0, once the wait counter reaches BUS_TIMEOUT-1 with hreadyd=0, the block SHALL pulse bus_timeout_err, release stall, clear the counter and go to CONT; hreadyd=1 in the same cycle wins (no error).
REQ-012 The wait counter SHALL clear on every WAITLD entry and exit, and saturate when BUS_TIMEOUT=0.
REQ-013 irq_ack SHALL be one-hot on irq_id for exactly the first IRQ cycle.
REQ-014 IRQ SHALL assert irq_bypass_inst_reg; urom_addr loads irq_id*IRQ_SEQ_LEN (mod 2**UROM_AW) on entry and increments once per cycle.
REQ-015 IRQ SHALL exit to CONT after IRQ_SEQ_LEN cycles; branch_taken during IRQ SHALL abort the sequence into BRANCH (output_new_pc, stall).
REQ-016 New interrupts SHALL NOT be taken while in IRQ; requests stay pending until the next eligible CONT cycle.
REQ-017 urom_addr SHALL hold its value outside IRQ.
REQ-018 Unused pstate encodings SHALL recover to CONT with default outputs.

Reset
REQ-019 rst=1 SHALL force pstate_r=RESET and clear urom_addr, irq_id, the wait counter and the sequence counter.
REQ-020 Under rst, registered outputs SHALL be 0; combinational outputs follow the RESET state.
REQ-021 rst mid-WAITLD or mid-IRQ SHALL abandon the operation with no irq_ack or bus_timeout_err emitted.

Structure
REQ-022 Pstate encodings and PSTATE width SHALL live in the shared nanorv32 parameters package; the module parameters stay local.
REQ-023 Priority select and irq_id capture SHALL be a sub-module nanorv32_irq_arb.

Verification
REQ-024 After rst release: pstate RESET→CONT in 1 cycle, with force_stall_reset=1 only during the RESET cycle.
REQ-025 Load with hreadyd low for 3 cycles, BUS_TIMEOUT=16: stall for 4 cycles, back to CONT, no error.
REQ-026 hreadyd held low, BUS_TIMEOUT=16: bus_timeout_err pulses at wait count 15, then CONT.
REQ-027 irq=4'b0110 in idle CONT: irq_ack=4'b0010 for 1 cycle, urom_addr 4,5,6,7, then CONT.
REQ-028 branch_taken and irq in the same CONT cycle: BRANCH taken, no irq_ack; interrupt taken after return to CONT.
REQ-029 rst asserted in the 2nd IRQ cycle: RESET state, urom_addr=0, no further irq_ack.
